// File: rtl/regfile_wb_port_pkg.sv
// Shared definitions for the register-file write-back port controller.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package regfile_wb_port_pkg;

    // R15 is the PC; it never takes a write through this port
    localparam logic [3:0] PC_IDX    = 4'd15;
    localparam int         NUM_REGS  = 15;
    localparam int         WB_DATA_W = 32;

    // Generic write request as seen on either source of the port
    typedef struct packed {
        logic [3:0]           addr;
        logic [WB_DATA_W-1:0] data;
        logic                 valid;
    } wb_req_t;

    // True when a destination may actually be written
    function automatic logic rf_writable(input logic [3:0] addr);
        return addr != PC_IDX;
    endfunction

endpackage

// File: rtl/regfile_wb_port_fifo.sv
// Circular buffer of MCycle results with per-entry valid bits and address-match kill.
// Latency: a push is visible at the head one cycle later; killed entries at the head are skipped in the same cycle.
// Backpressure: caller must not push while o_full; o_full is a pure function of the registered count.
module rfwb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [3:0]        i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_kill,
    input  logic [3:0]        i_kill_addr,
    input  logic              i_drain,
    output logic              o_head_vld,
    output logic [3:0]        o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_kill_hit,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]        r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W:0]    r_count;

    logic              w_found;
    logic [PTR_W-1:0]  w_sel;
    logic [PTR_W:0]    w_skip;
    logic [PTR_W:0]    w_pop_n;
    logic              w_take;

    // Find the first live entry from the read pointer; dead entries before it are discarded for free
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rptr;
        w_skip  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && ((PTR_W+1)'(i) < r_count)) begin
                if (r_vld[r_rptr + PTR_W'(i)]) begin
                    w_found = 1'b1;
                    w_sel   = r_rptr + PTR_W'(i);
                end else begin
                    w_skip = w_skip + 1'b1;
                end
            end
        end
    end

    // Any live entry targeting the register the pipeline is writing right now
    always_comb begin
        o_kill_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_kill && r_vld[i] && (r_addr[i] == i_kill_addr)) begin
                o_kill_hit = 1'b1;
            end
        end
    end

    assign w_take      = i_drain && w_found;
    assign w_pop_n     = w_skip + (PTR_W+1)'(w_take);
    assign o_head_vld  = w_found;
    assign o_head_addr = r_addr[w_sel];
    assign o_head_data = r_data[w_sel];
    assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty     = (r_count == '0);

    // Pointer, occupancy and valid-bit bookkeeping (kill, pop, then push into the free slot)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_vld[i] && (r_addr[i] == i_kill_addr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((PTR_W+1)'(i) < w_pop_n) begin
                    r_vld[r_rptr + PTR_W'(i)] <= 1'b0;
                end
            end
            if (i_push) begin
                // A result racing a pipeline write to the same register is stored dead
                r_vld[r_wptr] <= !(i_kill && (i_kill_addr == i_push_addr));
                r_wptr        <= r_wptr + 1'b1;
            end
            r_rptr  <= r_rptr + w_pop_n[PTR_W-1:0];
            r_count <= r_count + (PTR_W+1)'(i_push) - w_pop_n;
        end
    end

    // Payload storage; contents are only meaningful where the valid bit is set
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_wptr] <= i_push_addr;
            r_data[r_wptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_port.sv
// Owns the register-file write port: pipeline write-backs pass straight through, MCycle results queue and drain in idle cycles.
// Latency: pipeline 0 cycles; MCycle >=1 cycle after push, +1 per cycle the pipeline holds the port.
// Backpressure: McReady = !Full from registered count. Optional busy scoreboard under RFWB_SCOREBOARD_EN.
module regfile_wb_port
    import regfile_wb_port_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              PipeWE,
    input  logic [3:0]        PipeA3,
    input  logic [DATA_W-1:0] PipeWD,
    input  logic              McValid,
    input  logic [3:0]        McA3,
    input  logic [DATA_W-1:0] McWD,
    output logic              McReady,
    input  logic              IssueValid,
    input  logic [3:0]        IssueRd,
    output logic              WE3,
    output logic [3:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic [14:0]       Busy,
    output logic              Full,
    output logic              Empty
);

    logic              w_pipe_wr;
    logic              w_mc_push;
    logic              w_head_vld;
    logic [3:0]        w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_kill_hit;
    logic              w_full;
    logic              w_empty;
    logic              w_drain;

    // Reset gates the pass-through so the port is quiet while RESETn is low
    assign w_pipe_wr = RESETn && PipeWE && rf_writable(PipeA3);
    // PC-targeted results are accepted but never stored
    assign w_mc_push = McValid && McReady && rf_writable(McA3);
    assign w_drain   = !w_pipe_wr && w_head_vld;

    assign McReady = !w_full;
    assign Full    = w_full;
    assign Empty   = w_empty;

    rfwb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst_n     (RESETn),
        .i_push      (w_mc_push),
        .i_push_addr (McA3),
        .i_push_data (McWD),
        .i_kill      (w_pipe_wr),
        .i_kill_addr (PipeA3),
        .i_drain     (!w_pipe_wr),
        .o_head_vld  (w_head_vld),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_kill_hit  (w_kill_hit),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Port arbitration: pipeline first, then the FIFO head, otherwise idle zeros
    always_comb begin
        WE3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        if (w_pipe_wr) begin
            WE3 = 1'b1;
            A3  = PipeA3;
            WD3 = PipeWD;
        end else if (w_head_vld) begin
            WE3 = 1'b1;
            A3  = w_head_addr;
            WD3 = w_head_data;
        end
    end

`ifdef RFWB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_set;
    logic [NUM_REGS-1:0] w_busy_clr;

    // Set on issue; clear when the result is written or killed by a younger pipeline write
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (IssueValid && (IssueRd == 4'(i))) begin
                w_busy_set[i] = 1'b1;
            end
            if (w_drain && (w_head_addr == 4'(i))) begin
                w_busy_clr[i] = 1'b1;
            end
            if (w_pipe_wr && (PipeA3 == 4'(i)) &&
                (w_kill_hit || (w_mc_push && (McA3 == PipeA3)))) begin
                w_busy_clr[i] = 1'b1;
            end
        end
    end

    // Busy flops; a same-cycle issue overrides the clear
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign Busy = r_busy;
`else
    logic w_unused_issue;

    assign Busy           = '0;
    assign w_unused_issue = &{1'b0, IssueValid, IssueRd};
`endif

endmodule

// File: tb/tb_regfile_wb_port.sv
module tb_regfile_wb_port;

    logic        CLK;
    logic        RESETn;
    logic        PipeWE;
    logic [3:0]  PipeA3;
    logic [31:0] PipeWD;
    logic        McValid;
    logic [3:0]  McA3;
    logic [31:0] McWD;
    logic        McReady;
    logic        IssueValid;
    logic [3:0]  IssueRd;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [14:0] Busy;
    logic        Full;
    logic        Empty;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_wb_port #(.DEPTH(2), .DATA_W(32)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .PipeWE     (PipeWE),
        .PipeA3     (PipeA3),
        .PipeWD     (PipeWD),
        .McValid    (McValid),
        .McA3       (McA3),
        .McWD       (McWD),
        .McReady    (McReady),
        .IssueValid (IssueValid),
        .IssueRd    (IssueRd),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .Busy       (Busy),
        .Full       (Full),
        .Empty      (Empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Busy is only populated when the scoreboard is built in
    function automatic logic [14:0] eb(input logic [14:0] v);
`ifdef RFWB_SCOREBOARD_EN
        return v;
`else
        return v & 15'h0;
`endif
    endfunction

    task automatic idle();
        PipeWE = 0; PipeA3 = 0; PipeWD = 0;
        McValid = 0; McA3 = 0; McWD = 0;
        IssueValid = 0; IssueRd = 0;
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the next expected write
    always @(negedge CLK) begin
        if (WE3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%0h, expected no write", A3, WD3);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_a3_wd3", {28'd0, A3, WD3}, {28'd0, e.a, e.d});
            end
        end
    end

    initial begin
        RESETn = 0;
        idle();
        PipeWE = 1; PipeA3 = 3; PipeWD = 32'h55;
        #3;
        chk("rst_we3", 64'(WE3), 64'd0);
        chk("rst_a3", 64'(A3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_mcready", 64'(McReady), 64'd1);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_full", 64'(Full), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        nxt();
        RESETn = 1;
        idle();

        // Pipeline pass-through, then PC-targeted drop
        nxt(); PipeWE = 1; PipeA3 = 3; PipeWD = 32'h11; expect_wr(3, 32'h11);
        @(negedge CLK); chk("pipe_we", 64'(WE3), 64'd1);
        nxt(); PipeA3 = 15; PipeWD = 32'h22;
        @(negedge CLK); chk("pc_drop", 64'(WE3), 64'd0);

        // Single MCycle result, one-cycle latency
        nxt(); idle(); McValid = 1; McA3 = 5; McWD = 32'hAB; expect_wr(5, 32'hAB);
        @(negedge CLK); chk("mc_lat0", 64'(WE3), 64'd0);
        nxt(); idle();
        @(negedge CLK); chk("mc_lat1", 64'(WE3), 64'd1);
        chk("mc_nonempty", 64'(Empty), 64'd0);
        nxt();
        @(negedge CLK); chk("mc_empty", 64'(Empty), 64'd1);

        // Fill while the pipeline holds the port; a push while full is refused
        nxt(); PipeWE = 1; PipeA3 = 7; PipeWD = 32'h70; McValid = 1; McA3 = 1; McWD = 32'h1;
        expect_wr(7, 32'h70);
        nxt(); PipeA3 = 8; PipeWD = 32'h80; McA3 = 2; McWD = 32'h2;
        expect_wr(8, 32'h80);
        nxt(); PipeA3 = 9; PipeWD = 32'h90; McA3 = 10; McWD = 32'hDEAD;
        expect_wr(9, 32'h90);
        @(negedge CLK);
        chk("full_set", 64'(Full), 64'd1);
        chk("full_mcready", 64'(McReady), 64'd0);
        nxt(); idle();
        expect_wr(1, 32'h1);
        expect_wr(2, 32'h2);
        @(negedge CLK); chk("drain_r1", 64'(WE3), 64'd1);
        nxt();
        @(negedge CLK); chk("drain_r2", 64'(WE3), 64'd1);
        nxt();
        @(negedge CLK);
        chk("drain_empty", 64'(Empty), 64'd1);
        chk("drain_mcready", 64'(McReady), 64'd1);

        // WAW kill of a queued result
        nxt(); IssueValid = 1; IssueRd = 4;
        nxt(); idle(); McValid = 1; McA3 = 4; McWD = 32'h44;
        @(negedge CLK); chk("busy4_set", 64'(Busy), 64'(eb(15'h0010)));
        nxt(); idle(); PipeWE = 1; PipeA3 = 4; PipeWD = 32'h99; expect_wr(4, 32'h99);
        nxt(); idle();
        @(negedge CLK);
        chk("waw_skip", 64'(WE3), 64'd0);
        chk("busy4_clr", 64'(Busy), 64'd0);
        nxt();
        @(negedge CLK); chk("waw_empty", 64'(Empty), 64'd1);

        // Result pushed in the same cycle as a pipeline write to the same register
        nxt(); PipeWE = 1; PipeA3 = 11; PipeWD = 32'hB1; McValid = 1; McA3 = 11; McWD = 32'hB2;
        expect_wr(11, 32'hB1);
        nxt(); idle();
        @(negedge CLK); chk("push_kill", 64'(WE3), 64'd0);
        nxt();
        @(negedge CLK); chk("push_kill_empty", 64'(Empty), 64'd1);

        // Issue and drain of the same register in one cycle: set wins
        nxt(); IssueValid = 1; IssueRd = 6;
        nxt(); idle(); McValid = 1; McA3 = 6; McWD = 32'h66; expect_wr(6, 32'h66);
        nxt(); idle(); IssueValid = 1; IssueRd = 6;
        nxt(); idle();
        @(negedge CLK); chk("busy6_setwins", 64'(Busy), 64'(eb(15'h0040)));

        // Reset with two queued entries discards them
        nxt(); PipeWE = 1; PipeA3 = 12; PipeWD = 32'hC0; McValid = 1; McA3 = 13; McWD = 32'hD0;
        IssueValid = 1; IssueRd = 13;
        expect_wr(12, 32'hC0);
        nxt(); PipeWD = 32'hC1; McA3 = 14; McWD = 32'hE0; IssueValid = 0; IssueRd = 0;
        expect_wr(12, 32'hC1);
        nxt(); idle();
        chk("pre_rst_full", 64'(Full), 64'd1);
        chk("pre_rst_busy", 64'(Busy), 64'(eb(15'h2040)));
        RESETn = 0;
        #1;
        chk("mid_rst_we3", 64'(WE3), 64'd0);
        chk("mid_rst_busy", 64'(Busy), 64'd0);
        chk("mid_rst_empty", 64'(Empty), 64'd1);
        chk("mid_rst_full", 64'(Full), 64'd0);
        nxt();
        nxt(); RESETn = 1;
        nxt();
        @(negedge CLK); chk("post_rst_idle", 64'(WE3), 64'd0);
        nxt();
        nxt();
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_port.md
# regfile_wb_port

Write-back port controller that owns the register file's single write port (WE3/A3/WD3). Merges zero-latency pipeline write-backs (ALU/load results) with out-of-band results from the multi-cycle unit (multiplier/divider), buffers the latter in a small FIFO, and maintains a per-register busy scoreboard for the hazard unit. Sits between the pipeline's WB stage / MCycle unit and the register file.

## Interface
- DEPTH, 2, MCycle result FIFO entries (power of two, ≥2)
- DATA_W, 32, data width
- CLK  input  1  clock, rising edge
- RESETn  input  1  asynchronous, active-low reset
- PipeWE  input  1  pipeline write-back valid this cycle
- PipeA3  input  4  pipeline destination register
- PipeWD  input  DATA_W  pipeline write data
- McValid  input  1  MCycle result valid
- McA3  input  4  MCycle destination register
- McWD  input  DATA_W  MCycle result data
- McReady  output  1  FIFO can accept (= !Full)
- IssueValid  input  1  MCycle op issued; mark IssueRd busy
- IssueRd  input  4  destination of issued MCycle op
- WE3  output  1  register file write enable
- A3  output  4  register file write address
- WD3  output  DATA_W  register file write data
- Busy  output  15  bit i set = R(i) awaiting MCycle result
- Full, Empty  output  1  FIFO status

## Operation
- Register index 15 (PC) is never written: any request with address 4'd15 is dropped (pipeline: WE3 stays 0; MCycle: accepted, discarded, no FIFO entry).
- Port arbitration per cycle: PipeWE (addr ≠15) wins → WE3=1, A3=PipeA3, WD3=PipeWD, combinational pass-through. Otherwise, if FIFO head valid → WE3=1, A3/WD3 = head, head popped at clock edge. Otherwise WE3=0, A3=0, WD3=0.
- FIFO push on McValid && McReady at rising edge; entry not visible at head until next cycle.
- WAW kill: a pipeline write (PipeWE, addr ≠15) to register R kills every valid FIFO entry with destination R at the same edge; killed entries are popped without asserting WE3 (skipped, consume no port cycle). An MCycle result pushed in the same cycle to R is also killed.
- Scoreboard: Busy[IssueRd] set on IssueValid (IssueRd ≠15). Busy[R] cleared when an FIFO entry for R is written or killed. Set and clear of same R in same cycle → set wins.
- FIFO is circular; pointers wrap modulo DEPTH; Full when count==DEPTH, Empty when count==0. Simultaneous push and pop when Full is permitted only if pop occurs (McReady already low ⇒ no push when Full).

## Timing
- Reset (RESETn low, async): FIFO empty, pointers 0, Busy=0, WE3=0, A3=0, WD3=0, McReady=1, Empty=1, Full=0. Outputs forced inactive while RESETn low, even if PipeWE=1.
- Reset mid-operation: pending FIFO entries discarded, never written.
- Pipeline latency 0 cycles (same-cycle WE3). MCycle latency ≥1 cycle: pushed at edge N, written in cycle N+1 if no PipeWE; each PipeWE cycle delays the drain by one cycle.
- McReady is a pure function of registered count (no combinational path from McValid).

## Configuration
- RFWB_SCOREBOARD_EN defined: Busy scoreboard implemented as above.
- Not defined: Busy tied to 15'd0, IssueValid/IssueRd ignored, no scoreboard flops; FIFO, arbitration and WAW kill unchanged.

## Structure
- Shared package: PC_IDX=4'd15, NUM_REGS=15, write-request struct/typedef {addr[3:0], data[DATA_W-1:0], valid}.
- One sub-module: rfwb_fifo — circular DEPTH-entry buffer with per-entry valid bits and address-match kill input; top level holds arbitration and scoreboard.

## Test plan
- Reset, then PipeWE=1, PipeA3=3, PipeWD=0x11 → same cycle WE3=1, A3=3, WD3=0x11; PipeA3=15 → WE3=0.
- McValid with A3=5, WD=0xAB, no PipeWE → WE3=1, A3=5, WD3=0xAB exactly one cycle after push; Empty returns to 1.
- Push two MCycle results (R1=0x1, R2=0x2) while PipeWE held 3 cycles → Full=1, McReady=0; after PipeWE drops, R1 then R2 written on consecutive cycles.
- IssueValid R4, MCycle result R4 queued, PipeWE to R4=0x99 before drain → queued entry killed, never written; Busy[4] clears; R4 final write 0x99.
- IssueValid R6 in same cycle R6 entry drains → Busy[6] stays 1 (set wins).
- Assert RESETn low with 2 queued entries → no further WE3, Busy=0, Empty=1 immediately.
